// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC/[MEM]/WB sequencer with handshaked instruction and data ports.
// 16-bit instruction {op,M,rd,rs1,rs2|imm8}; parametrised data/address width and register count.
module cpu_multicycle #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [15:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [7:0]            dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [15:0]           Instruction,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  halted
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_BEZ = 3'b110;
  localparam logic [2:0] OP_SYS = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t                state, state_nxt;
  logic [15:0]           ir;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] a_q, b_q, alu_q, mdr;
  logic [DATA_WIDTH-1:0] alu_y, wr_data;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  logic [2:0]    op;
  logic          m;
  logic [RW-1:0] rd_idx, rs1_idx, rs2_idx, a_idx;
  logic [7:0]    imm;
  logic          take, wr_en;

  assign op      = ir[15:13];
  assign m       = ir[12];
  assign rd_idx  = ir[8 +: RW];
  assign rs1_idx = ir[4 +: RW];
  assign rs2_idx = ir[0 +: RW];
  assign imm     = ir[7:0];
  // ST and BEZ operate on R[rd], so it is routed through the A operand
  assign a_idx   = (op == OP_ST || op == OP_BEZ) ? rd_idx : rs1_idx;

  function automatic logic rf_live(input logic [RW-1:0] idx);
    return !(R0_ZERO && idx == '0) && (int'(idx) < NUM_REGS);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [RW-1:0] idx);
    return rf_live(idx) ? rf[idx] : '0;
  endfunction

  always_comb begin
    alu_y = '0;
    case (op[1:0])
      2'b00: alu_y = a_q + b_q;
      2'b01: alu_y = a_q - b_q;
      2'b10: alu_y = a_q & b_q;
      2'b11: alu_y = a_q | b_q;
      default: alu_y = '0;
    endcase
  end

  assign take    = (op == OP_BEZ && a_q == '0) || (op == OP_SYS && m);
  assign wr_en   = (state == S_WB) && (!op[2] || op == OP_LD) && rf_live(rd_idx);
  assign wr_data = (op == OP_LD) ? mdr : (m ? alu_q : DATA_WIDTH'(imm));

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_LD || op == OP_ST)  state_nxt = S_MEM;
        else if (op == OP_SYS && !m)     state_nxt = S_HALT;
        else                             state_nxt = S_WB;
      end
      S_MEM:    if (dmem_ready) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH:  if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          a_q <= rf_read(a_idx);
          b_q <= rf_read(rs2_idx);
        end
        S_EXEC:   alu_q <= alu_y;
        S_MEM:    if (dmem_ready && op == OP_LD) mdr <= dmem_rdata;
        S_WB:     pc <= take ? ADDR_WIDTH'(imm) : pc + ADDR_WIDTH'(1);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[rd_idx] <= wr_data;
    end
  end

  // RESET gates imem_req so no fetch is advertised while the core is held
  assign imem_req    = (state == S_FETCH) && !RESET;
  assign imem_addr   = pc;
  assign dmem_req    = (state == S_MEM);
  assign dmem_we     = (state == S_MEM) && (op == OP_ST);
  assign dmem_addr   = imm;
  assign dmem_wdata  = a_q;
  assign Instruction = ir;
  assign ALUResult   = alu_q;
  assign PC          = pc;
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: instruction/data memory models with programmable data wait states,
// plus a second instance at DATA_WIDTH=16, NUM_REGS=4.
module tb_cpu_multicycle;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
  logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, ALUResult, PC;
  logic [15:0] imem_rdata, Instruction;

  logic        rst2 = 1'b1;
  logic        w_imem_req, w_imem_ready, w_dmem_req, w_dmem_we, w_dmem_ready, w_halted;
  logic [7:0]  w_imem_addr, w_dmem_addr, w_pc;
  logic [15:0] w_imem_rdata, w_instr, w_dmem_wdata, w_dmem_rdata, w_alu;

  logic [15:0] imem  [256];
  logic [7:0]  dmem  [256];
  logic [15:0] imem2 [256];
  int          dmem_delay = 0;
  int          dcnt = 0;
  logic        force_rdy = 1'b0;
  int          w_st_cnt = 0;
  logic [7:0]  w_st_addr = '0;
  logic [15:0] w_st_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cpu_multicycle dut (
    .CLK(CLK), .RESET(RESET),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .Instruction(Instruction), .ALUResult(ALUResult), .PC(PC), .halted(halted)
  );

  cpu_multicycle #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(4), .R0_ZERO(1'b1)) dut16 (
    .CLK(CLK), .RESET(rst2),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(w_imem_ready), .imem_rdata(w_imem_rdata),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata),
    .dmem_ready(w_dmem_ready), .dmem_rdata(w_dmem_rdata),
    .Instruction(w_instr), .ALUResult(w_alu), .PC(w_pc), .halted(w_halted)
  );

  // Memory models: instruction side never waits, data side waits dmem_delay cycles per access
  assign imem_ready = 1'b1;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ready = (dmem_req && dcnt >= dmem_delay) || force_rdy;
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge CLK) begin
    if (dmem_req && dmem_ready) begin
      if (dmem_we) dmem[dmem_addr] = dmem_wdata;
      dcnt <= 0;
    end else if (dmem_req) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  assign w_imem_ready = 1'b1;
  assign w_imem_rdata = imem2[w_imem_addr];
  assign w_dmem_ready = w_dmem_req;
  assign w_dmem_rdata = 16'h0;

  always @(posedge CLK) begin
    if (w_dmem_req && w_dmem_we) begin
      w_st_cnt  = w_st_cnt + 1;
      w_st_addr = w_dmem_addr;
      w_st_data = w_dmem_wdata;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hE000;
      dmem[i] = 8'h00;
    end
  endtask

  // Steps negedges from a FETCH until the next FETCH; records any data access seen on the way
  task automatic wait_req(output int n, output logic s_req, output logic s_we,
                          output logic [7:0] s_addr, output logic [7:0] s_wd);
    n = 0; s_req = 0; s_we = 0; s_addr = 0; s_wd = 0;
    do begin
      @(negedge CLK);
      n++;
      if (dmem_req) begin
        s_req = 1'b1; s_we = s_we | dmem_we; s_addr = dmem_addr; s_wd = dmem_wdata;
      end
    end while (!imem_req && n < 100);
  endtask

  task automatic wait_req2(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!w_imem_req && n < 100);
  endtask

  task automatic test_reset();
    clear_mem();
    imem[8'h00] = 16'h0105; imem[8'h01] = 16'h0203; imem[8'h02] = 16'h1312; imem[8'h03] = 16'h3421;
    imem[8'h04] = 16'hA310; imem[8'h05] = 16'h8510; imem[8'h06] = 16'hA512; imem[8'h07] = 16'hC020;
    imem[8'h20] = 16'hC130; imem[8'h21] = 16'hF024; imem[8'h24] = 16'hF000;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %0h expected 0", PC); end
    checks++; if (Instruction !== 16'h0) begin errors++; $display("FAIL reset_ir: got %0h expected 0", Instruction); end
    checks++; if (ALUResult !== 8'h00) begin errors++; $display("FAIL reset_alu: got %0h expected 0", ALUResult); end
    checks++; if ({halted, imem_req, dmem_req, dmem_we} !== 4'b0000)
      begin errors++; $display("FAIL reset_ctl: got %b expected 0000", {halted, imem_req, dmem_req, dmem_we}); end
    RESET = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      begin errors++; $display("FAIL reset_fetch: got req=%b addr=%0h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_alu();
    int n; logic r, w; logic [7:0] a, d;
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4) begin errors++; $display("FAIL movi1_cycles: got %0d expected 4", n); end
    checks++; if (PC !== 8'h01) begin errors++; $display("FAIL movi1_pc: got %0h expected 1", PC); end
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4) begin errors++; $display("FAIL movi2_cycles: got %0d expected 4", n); end
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4) begin errors++; $display("FAIL add_cycles: got %0d expected 4", n); end
    checks++; if (ALUResult !== 8'h08) begin errors++; $display("FAIL add_result: got %0h expected 08", ALUResult); end
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4) begin errors++; $display("FAIL sub_cycles: got %0d expected 4", n); end
    checks++; if (ALUResult !== 8'hFE) begin errors++; $display("FAIL sub_result: got %0h expected fe", ALUResult); end
    checks++; if (PC !== 8'h04) begin errors++; $display("FAIL sub_pc: got %0h expected 4", PC); end
  endtask

  task automatic test_mem();
    int n; logic r, w; logic [7:0] a, d;
    dmem_delay = 3;
    wait_req(n, r, w, a, d);
    checks++; if (n !== 8) begin errors++; $display("FAIL st_cycles: got %0d expected 8", n); end
    checks++; if (w !== 1'b1 || a !== 8'h10 || d !== 8'h08)
      begin errors++; $display("FAIL st_bus: got we=%b addr=%0h data=%0h expected we=1 addr=10 data=08", w, a, d); end
    checks++; if (dmem[8'h10] !== 8'h08) begin errors++; $display("FAIL st_mem: got %0h expected 08", dmem[8'h10]); end
    wait_req(n, r, w, a, d);
    checks++; if (n !== 8) begin errors++; $display("FAIL ld_cycles: got %0d expected 8", n); end
    checks++; if (r !== 1'b1 || w !== 1'b0)
      begin errors++; $display("FAIL ld_bus: got req=%b we=%b expected req=1 we=0", r, w); end
    wait_req(n, r, w, a, d);
    checks++; if (d !== 8'h08 || dmem[8'h12] !== 8'h08)
      begin errors++; $display("FAIL ld_value: got wdata=%0h mem=%0h expected 08", d, dmem[8'h12]); end
    dmem_delay = 0;
  endtask

  task automatic test_branch();
    int n; logic r, w; logic [7:0] a, d;
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4 || PC !== 8'h20)
      begin errors++; $display("FAIL bez_taken: got cycles=%0d pc=%0h expected 4 20", n, PC); end
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4 || PC !== 8'h21)
      begin errors++; $display("FAIL bez_not_taken: got cycles=%0d pc=%0h expected 4 21", n, PC); end
    wait_req(n, r, w, a, d);
    checks++; if (PC !== 8'h24) begin errors++; $display("FAIL jmp_fwd: got %0h expected 24", PC); end
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4 || PC !== 8'h00 || imem_addr !== 8'h00)
      begin errors++; $display("FAIL jmp_loop: got cycles=%0d pc=%0h expected 4 0", n, PC); end
    wait_req(n, r, w, a, d);
    checks++; if (PC !== 8'h01) begin errors++; $display("FAIL loop_again: got %0h expected 1", PC); end
  endtask

  task automatic test_halt();
    int n, reqs; logic r, w; logic [7:0] a, d;
    RESET = 1'b1;
    clear_mem();
    imem[8'h00] = 16'h0107; imem[8'h01] = 16'hE000;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    wait_req(n, r, w, a, d);
    repeat (2) @(negedge CLK);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
    @(negedge CLK);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
    reqs = 0;
    repeat (20) begin
      @(negedge CLK);
      if (imem_req || dmem_req) reqs++;
    end
    checks++; if (reqs !== 0) begin errors++; $display("FAIL halt_reqs: got %0d expected 0", reqs); end
    checks++; if (PC !== 8'h01 || halted !== 1'b1)
      begin errors++; $display("FAIL halt_pc: got pc=%0h halted=%b expected 1 1", PC, halted); end
    RESET = 1'b1;
    #1;
    checks++; if (PC !== 8'h00 || halted !== 1'b0 || imem_req !== 1'b0)
      begin errors++; $display("FAIL halt_reset: got pc=%0h halted=%b req=%b expected 0 0 0", PC, halted, imem_req); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4 || PC !== 8'h01)
      begin errors++; $display("FAIL halt_resume: got cycles=%0d pc=%0h expected 4 1", n, PC); end
  endtask

  task automatic test_wrap();
    int n; logic r, w; logic [7:0] a, d;
    RESET = 1'b1;
    clear_mem();
    imem[8'h00] = 16'hF0FF; imem[8'hFF] = 16'h0109;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    wait_req(n, r, w, a, d);
    checks++; if (PC !== 8'hFF) begin errors++; $display("FAIL wrap_jmp: got %0h expected ff", PC); end
    wait_req(n, r, w, a, d);
    checks++; if (n !== 4 || PC !== 8'h00)
      begin errors++; $display("FAIL wrap_pc: got cycles=%0d pc=%0h expected 4 0", n, PC); end
  endtask

  task automatic test_reset_mem();
    int n, k; logic r, w; logic [7:0] a, d;
    RESET = 1'b1;
    clear_mem();
    imem[8'h00] = 16'h0155; imem[8'h01] = 16'hA140;
    dmem[8'h40] = 8'hAA;
    dmem_delay = 10;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    wait_req(n, r, w, a, d);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!dmem_req && k < 10);
    checks++; if (k !== 3) begin errors++; $display("FAIL st_mem_entry: got %0d expected 3", k); end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || PC !== 8'h00)
      begin errors++; $display("FAIL rst_mem_drop: got req=%b we=%b pc=%0h expected 0 0 0", dmem_req, dmem_we, PC); end
    @(negedge CLK);
    force_rdy = 1'b1;
    RESET = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      begin errors++; $display("FAIL rst_mem_refetch: got req=%b addr=%0h expected 1 0", imem_req, imem_addr); end
    wait_req(n, r, w, a, d);
    force_rdy = 1'b0;
    checks++; if (n !== 4 || PC !== 8'h01 || r !== 1'b0)
      begin errors++; $display("FAIL rst_mem_late_ready: got cycles=%0d pc=%0h dreq=%b expected 4 1 0", n, PC, r); end
    checks++; if (dmem[8'h40] !== 8'hAA) begin errors++; $display("FAIL rst_mem_unchanged: got %0h expected aa", dmem[8'h40]); end
  endtask

  task automatic test_dw16();
    int n;
    for (int i = 0; i < 256; i++) imem2[i] = 16'hE000;
    imem2[0] = 16'h0100; imem2[1] = 16'h0201; imem2[2] = 16'h3312; imem2[3] = 16'h1332;
    imem2[4] = 16'h0577; imem2[5] = 16'hA130;
    @(negedge CLK);
    rst2 = 1'b0;
    #1;
    wait_req2(n);
    wait_req2(n);
    wait_req2(n);
    checks++; if (w_alu !== 16'hFFFF) begin errors++; $display("FAIL dw16_sub: got %0h expected ffff", w_alu); end
    wait_req2(n);
    checks++; if (n !== 4 || w_alu !== 16'h0000)
      begin errors++; $display("FAIL dw16_add_wrap: got cycles=%0d alu=%0h expected 4 0", n, w_alu); end
    wait_req2(n);
    wait_req2(n);
    checks++; if (w_st_cnt !== 1 || w_st_addr !== 8'h30 || w_st_data !== 16'h0077)
      begin errors++; $display("FAIL dw16_rd_alias: got cnt=%0d addr=%0h data=%0h expected 1 30 0077", w_st_cnt, w_st_addr, w_st_data); end
    repeat (3) @(negedge CLK);
    checks++; if (w_halted !== 1'b1) begin errors++; $display("FAIL dw16_halt: got %b expected 1", w_halted); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_mem();
    test_dw16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
